fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer_if.sv | 30 +++
 rtl/fetch_buffer.sv | 79 +++++++
 tb/tb_fetch_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch buffer.
// The master side is the fetch/branch/decode environment; the slave side is the buffer.
interface fetch_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_kill;
    logic          i_wr_en;
    logic [31:0]   i_wr_instr;
    logic [31:0]   i_wr_pc;
    logic          i_stall;
    logic          o_full;
    logic          o_empty;
    logic [CW-1:0] o_count;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc;
    logic          o_imask;
    logic          o_en;

    modport master (
        output i_kill, i_wr_en, i_wr_instr, i_wr_pc, i_stall,
        input  o_full, o_empty, o_count, o_instr, o_pc, o_imask, o_en
    );

    modport slave (
        input  i_kill, i_wr_en, i_wr_instr, i_wr_pc, i_stall,
        output o_full, o_empty, o_count, o_instr, o_pc, o_imask, o_en
    );
endinterface

// File: rtl/fetch_buffer.sv
// Circular first-word-fall-through instruction buffer between fetch and decode.
// Kill flushes pointers and count; storage is never cleared.
module fetch_buffer #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_buffer_if.slave fb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Status comes only from the registered count, never from this cycle's strobes.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    assign pop  = !empty && !fb.i_stall && !fb.i_kill;
    assign push = fb.i_wr_en && !full && !fb.i_kill;

    assign fb.o_empty = empty;
    assign fb.o_full  = full;
    assign fb.o_count = count_q;
    assign fb.o_imask = !empty;
    assign fb.o_en    = pop;
    assign fb.o_instr = empty ? NOP   : instr_mem_q[rd_ptr_q];
    assign fb.o_pc    = empty ? '0    : pc_mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (fb.i_kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload has no reset; a stale slot is unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= fb.i_wr_instr;
            pc_mem_q[wr_ptr_q]    <= fb.i_wr_pc;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed vector bench for fetch_buffer (DEPTH=8): table of stimulus/expected records
// plus a hand-written reset-during-operation sequence.
module tb_fetch_buffer;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic        rst;
        logic        kill;
        logic        wr;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  e_count;
        logic        e_full;
        logic        e_empty;
        logic        e_imask;
        logic        e_en;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fetch_buffer_if #(.DEPTH(8)) bus ();

    fetch_buffer #(.DEPTH(8), .NOP(NOP)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .fb    (bus.slave)
    );

    // Expected outputs for the cycle: occupancy and head entry before the edge.
    function automatic vec_t mk(input logic r, input logic k, input logic w, input logic s,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input int cnt, input logic [31:0] hpc, input logic [31:0] hinstr);
        vec_t v;
        v.rst     = r;
        v.kill    = k;
        v.wr      = w;
        v.stall   = s;
        v.pc      = pc;
        v.instr   = instr;
        v.e_count = 4'(cnt);
        v.e_full  = (cnt == 8);
        v.e_empty = (cnt == 0);
        v.e_imask = (cnt != 0);
        v.e_en    = (cnt != 0) && !s && !k;
        v.e_pc    = (cnt == 0) ? 32'h0 : hpc;
        v.e_instr = (cnt == 0) ? NOP   : hinstr;
        return v;
    endfunction

    // Called right after a rising edge: drive, check mid-cycle, advance one edge.
    task automatic apply(input vec_t v, input int idx);
        rst            = v.rst;
        bus.i_kill     = v.kill;
        bus.i_wr_en    = v.wr;
        bus.i_stall    = v.stall;
        bus.i_wr_pc    = v.pc;
        bus.i_wr_instr = v.instr;
        #2;
        vectors++;
        if (bus.o_count !== v.e_count || bus.o_full !== v.e_full || bus.o_empty !== v.e_empty ||
            bus.o_imask !== v.e_imask || bus.o_en !== v.e_en || bus.o_pc !== v.e_pc ||
            bus.o_instr !== v.e_instr) begin
            miscompares++;
            $display("FAIL vec%0d: got count=%0d full=%b empty=%b imask=%b en=%b pc=%h instr=%h, want count=%0d full=%b empty=%b imask=%b en=%b pc=%h instr=%h",
                     idx, bus.o_count, bus.o_full, bus.o_empty, bus.o_imask, bus.o_en, bus.o_pc, bus.o_instr,
                     v.e_count, v.e_full, v.e_empty, v.e_imask, v.e_en, v.e_pc, v.e_instr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Basic single entry, and stall on an empty buffer.
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0,0,1,0, 32'h100, 32'h00500093, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 1, 32'h100, 32'h00500093));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0,0,0,1, 32'h0, 32'h0, 0, 32'h0, 32'h0));
        // Fill while stalled, drop the 9th write, then drain without bubbles.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,1, 32'(i*4), 32'hA000_0000 + 32'(i), i, 32'h0, 32'hA000_0000));
        tbl.push_back(mk(0,0,1,1, 32'h20, 32'hBAD0_0000, 8, 32'h0, 32'hA000_0000));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 8-k, 32'(k*4), 32'hA000_0000 + 32'(k)));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0));
        // Steady push+pop over 20 cycles: count holds at 1, pointers wrap twice.
        tbl.push_back(mk(0,0,1,0, 32'h200, 32'h1000_0200, 0, 32'h0, 32'h0));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(0,0,1,0, 32'h204 + 32'(4*k), 32'h1000_0204 + 32'(4*k),
                             1, 32'h200 + 32'(4*k), 32'h1000_0200 + 32'(4*k)));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 1, 32'h250, 32'h1000_0250));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0));
        // Five entries, then kill together with a write.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,1,1, 32'h300 + 32'(4*i), 32'h2000_0300 + 32'(4*i), i, 32'h300, 32'h2000_0300));
        tbl.push_back(mk(0,1,1,0, 32'h3F0, 32'h2000_03F0, 5, 32'h300, 32'h2000_0300));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0));
        // Full buffer with a write and a pop in the same cycle: the write is lost.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,1, 32'h400 + 32'(4*i), 32'h3000_0400 + 32'(4*i), i, 32'h400, 32'h3000_0400));
        tbl.push_back(mk(0,0,1,0, 32'h4F0, 32'h3000_04F0, 8, 32'h400, 32'h3000_0400));
        for (int k = 1; k < 8; k++)
            tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 8-k, 32'h400 + 32'(4*k), 32'h3000_0400 + 32'(4*k)));
        tbl.push_back(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0));

        rst            = 1'b1;
        bus.i_kill     = 1'b0;
        bus.i_wr_en    = 1'b0;
        bus.i_stall    = 1'b0;
        bus.i_wr_pc    = '0;
        bus.i_wr_instr = '0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset mid-operation, asserted together with kill, a write and an unstalled head.
        apply(mk(0,0,1,1, 32'h500, 32'h4000_0500, 0, 32'h0, 32'h0), 1000);
        apply(mk(0,0,1,1, 32'h504, 32'h4000_0504, 1, 32'h500, 32'h4000_0500), 1001);
        apply(mk(0,0,1,1, 32'h508, 32'h4000_0508, 2, 32'h500, 32'h4000_0500), 1002);
        apply(mk(1,1,1,0, 32'h50C, 32'h4000_050C, 3, 32'h500, 32'h4000_0500), 1003);
        apply(mk(0,0,0,1, 32'h0, 32'h0, 0, 32'h0, 32'h0), 1004);
        apply(mk(0,0,1,1, 32'h600, 32'h4000_0600, 0, 32'h0, 32'h0), 1005);
        apply(mk(0,0,0,1, 32'h0, 32'h0, 1, 32'h600, 32'h4000_0600), 1006);
        // Reset alone while holding an entry and a stalled head.
        apply(mk(1,0,0,1, 32'h0, 32'h0, 1, 32'h600, 32'h4000_0600), 1007);
        apply(mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 32'h0), 1008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got stuck, want finish");
        $fatal(1, "timeout");
    end
endmodule
